// File: rtl/pong_pkg.sv
// Shared definitions for the Pong frame-buffer writer.
//   H_RES_DEF / V_RES_DEF : default screen geometry
//   COORD_W               : width of the x/y scan coordinates sent to the renderer
//   RGB_W                 : RGB555 pixel width written to the frame buffer
//   pong_state_e          : scan FSM encoding
package pong_pkg;

  localparam int H_RES_DEF = 800;
  localparam int V_RES_DEF = 600;
  localparam int COORD_W   = 11;
  localparam int RGB_W     = 15;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SCAN  = 2'd1,
    ST_DRAIN = 2'd2
  } pong_state_e;

endpackage

// File: rtl/pong_pix_fifo.sv
// Synchronous pixel FIFO with same-cycle push/pop and an occupancy count.
//   clock, reset     : rising-edge clock, async active-high reset
//   push, push_data  : write an entry (accepted when not full, or when popping)
//   pop              : remove the head entry (ignored when empty)
//   head             : current head entry, all-zero after reset
//   empty, count     : occupancy status
module pong_pix_fifo #(
  parameter int WIDTH = 34,
  parameter int DEPTH = 4,
  localparam int CNT_W = $clog2(DEPTH + 1)
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] head,
  output logic             empty,
  output logic [CNT_W-1:0] count
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] mem_d [DEPTH];
  logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             do_push, do_pop, full;

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
  endfunction

  assign empty = (count_q == '0);
  assign full  = (count_q == CNT_W'(DEPTH));
  assign head  = mem_q[rd_ptr_q];
  assign count = count_q;

  always_comb begin
    do_pop   = pop && !empty;
    // A push into a full FIFO is fine as long as the head leaves this cycle.
    do_push  = push && (!full || do_pop);
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (do_push) begin
      mem_d[wr_ptr_q] = push_data;
      wr_ptr_d        = ptr_inc(wr_ptr_q);
    end
    if (do_pop) begin
      rd_ptr_d = ptr_inc(rd_ptr_q);
    end
    case ({do_push, do_pop})
      2'b10:   count_d = count_q + CNT_W'(1);
      2'b01:   count_d = count_q - CNT_W'(1);
      default: count_d = count_q;
    endcase
  end

  // Storage is cleared on reset so the head (and the write port) reads zero.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      mem_q    <= mem_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

endmodule

// File: rtl/pong_fb_writer.sv
// Frame-scan writer between the Pong renderer and the frame-buffer controller.
// On frame_start it sweeps x/y across the screen, samples the renderer result
// RENDER_LAT+1 edges after each issue, and queues RGB555 writes for the
// frame buffer over a valid/ready handshake.
//   clock, reset                 : rising-edge clock, async active-high reset
//   frame_start                  : pulse to start a frame scan
//   x, y, coord_valid            : registered scan coordinate to the renderer
//   pong_cRGB, updatePixel       : renderer result {write_en, R5, G5, B5} and update flag
//   wr_valid/ready, addr, data   : frame-buffer write request
//   busy, frame_done             : scan in progress / frame fully written pulse
//   frame_overrun                : pulse when frame_start arrives while busy
//
// state    | meaning
// ST_IDLE  | waiting for frame_start
// ST_SCAN  | issuing coordinates under FIFO credit
// ST_DRAIN | all coordinates issued, waiting for pipe and FIFO to empty
module pong_fb_writer
  import pong_pkg::*;
#(
  parameter int H_RES      = H_RES_DEF,
  parameter int V_RES      = V_RES_DEF,
  parameter int RENDER_LAT = 0,
  parameter int FIFO_DEPTH = 4,
  parameter int ADDR_W     = 19
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              frame_start,
  output logic [10:0]       x,
  output logic [10:0]       y,
  output logic              coord_valid,
  input  logic [15:0]       pong_cRGB,
  input  logic              updatePixel,
  output logic              wr_valid,
  input  logic              wr_ready,
  output logic [ADDR_W-1:0] wr_addr,
  output logic [14:0]       wr_data,
  output logic              busy,
  output logic              frame_done,
  output logic              frame_overrun
);

  localparam int PIPE_N = RENDER_LAT + 1;
  localparam int CNT_W  = $clog2(FIFO_DEPTH + 1);
  localparam int CW     = CNT_W + 1;
  localparam logic [COORD_W-1:0] X_LAST = COORD_W'(H_RES - 1);
  localparam logic [COORD_W-1:0] Y_LAST = COORD_W'(V_RES - 1);

  pong_state_e state_q, state_d;
  logic [COORD_W-1:0] nx_q, nx_d, ny_q, ny_d;   // next coordinate to issue
  logic [COORD_W-1:0] x_q, x_d, y_q, y_d;
  logic [ADDR_W-1:0]  addr_q, addr_d;            // address of (nx, ny)
  logic               coord_valid_q, coord_valid_d;
  logic               busy_q, busy_d;
  logic               frame_done_q, frame_done_d;
  logic               frame_overrun_q, frame_overrun_d;
  logic               pipe_v_q [PIPE_N];
  logic               pipe_v_d [PIPE_N];
  logic [ADDR_W-1:0]  pipe_a_q [PIPE_N];
  logic [ADDR_W-1:0]  pipe_a_d [PIPE_N];

  logic [CW-1:0]      inflight;
  logic               credit, issue, fifo_push, fifo_pop, fifo_empty;
  logic [CNT_W-1:0]   fifo_count;
  logic [ADDR_W+RGB_W-1:0] fifo_head;

  pong_pix_fifo #(
    .WIDTH (ADDR_W + RGB_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clock     (clock),
    .reset     (reset),
    .push      (fifo_push),
    .push_data ({pipe_a_q[PIPE_N-1], pong_cRGB[RGB_W-1:0]}),
    .pop       (fifo_pop),
    .head      (fifo_head),
    .empty     (fifo_empty),
    .count     (fifo_count)
  );

  assign wr_valid      = !fifo_empty;
  assign {wr_addr, wr_data} = fifo_head;
  assign fifo_pop      = wr_valid && wr_ready;
  // Pixels not flagged for writing are dropped here; their credit retires anyway.
  assign fifo_push     = pipe_v_q[PIPE_N-1] && updatePixel && pong_cRGB[15];

  assign x             = x_q;
  assign y             = y_q;
  assign coord_valid   = coord_valid_q;
  assign busy          = busy_q;
  assign frame_done    = frame_done_q;
  assign frame_overrun = frame_overrun_q;

  // Credit counts queued pixels plus everything still in the render pipe, so a
  // sampled pixel always finds room. The same-cycle pop is deliberately ignored.
  always_comb begin
    inflight = '0;
    for (int i = 0; i < PIPE_N; i++) inflight = inflight + CW'(pipe_v_q[i]);
    credit = ((CW'(fifo_count) + inflight) < CW'(FIFO_DEPTH));
  end

  always_comb begin
    state_d         = state_q;
    nx_d            = nx_q;
    ny_d            = ny_q;
    x_d             = x_q;
    y_d             = y_q;
    addr_d          = addr_q;
    coord_valid_d   = 1'b0;
    frame_done_d    = 1'b0;
    frame_overrun_d = frame_start && (state_q != ST_IDLE);
    issue           = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (frame_start) begin
          state_d = ST_SCAN;
          nx_d    = '0;
          ny_d    = '0;
          x_d     = '0;
          y_d     = '0;
          addr_d  = '0;
        end
      end
      ST_SCAN: begin
        if (credit) begin
          issue         = 1'b1;
          x_d           = nx_q;
          y_d           = ny_q;
          coord_valid_d = 1'b1;
          addr_d        = addr_q + ADDR_W'(1);
          if (nx_q == X_LAST) begin
            nx_d = '0;
            if (ny_q == Y_LAST) state_d = ST_DRAIN;
            else                ny_d    = ny_q + COORD_W'(1);
          end else begin
            nx_d = nx_q + COORD_W'(1);
          end
        end
      end
      ST_DRAIN: begin
        if ((inflight == '0) && fifo_empty) begin
          state_d      = ST_IDLE;
          frame_done_d = 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
    busy_d = (state_d != ST_IDLE);
  end

  always_comb begin
    pipe_v_d[0] = issue;
    pipe_a_d[0] = addr_q;
    for (int i = 1; i < PIPE_N; i++) begin
      pipe_v_d[i] = pipe_v_q[i-1];
      pipe_a_d[i] = pipe_a_q[i-1];
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q         <= ST_IDLE;
      nx_q            <= '0;
      ny_q            <= '0;
      x_q             <= '0;
      y_q             <= '0;
      addr_q          <= '0;
      coord_valid_q   <= 1'b0;
      busy_q          <= 1'b0;
      frame_done_q    <= 1'b0;
      frame_overrun_q <= 1'b0;
      for (int i = 0; i < PIPE_N; i++) begin
        pipe_v_q[i] <= 1'b0;
        pipe_a_q[i] <= '0;
      end
    end else begin
      state_q         <= state_d;
      nx_q            <= nx_d;
      ny_q            <= ny_d;
      x_q             <= x_d;
      y_q             <= y_d;
      addr_q          <= addr_d;
      coord_valid_q   <= coord_valid_d;
      busy_q          <= busy_d;
      frame_done_q    <= frame_done_d;
      frame_overrun_q <= frame_overrun_d;
      pipe_v_q        <= pipe_v_d;
      pipe_a_q        <= pipe_a_d;
    end
  end

endmodule

// File: tb/tb_pong_fb_writer.sv
// Directed bench for pong_fb_writer on an 8x4 screen. One instance uses a
// combinational renderer, a second uses RENDER_LAT=2 with a 2-stage renderer.
module tb_pong_fb_writer;

  localparam int H = 8;
  localparam int V = 4;
  localparam int AW = 5;

  logic          clock = 1'b0;
  logic          reset = 1'b1;
  always #5 clock = ~clock;

  // instance 0: combinational renderer
  logic          frame_start = 1'b0;
  logic [10:0]   x, y;
  logic          coord_valid;
  logic [15:0]   pong_cRGB;
  logic          updatePixel;
  logic          wr_valid, wr_ready = 1'b0;
  logic [AW-1:0] wr_addr;
  logic [14:0]   wr_data;
  logic          busy, frame_done, frame_overrun;
  int            mode = 0;

  // instance 1: two-stage renderer
  logic          frame_start2 = 1'b0;
  logic [10:0]   x2, y2;
  logic          coord_valid2;
  logic [15:0]   pong_cRGB2;
  logic          wr_valid2, wr_ready2 = 1'b0;
  logic [AW-1:0] wr_addr2;
  logic [14:0]   wr_data2;
  logic          busy2, frame_done2, frame_overrun2;
  logic [14:0]   r1, r2;

  assign pong_cRGB   = (mode == 1 && x[0]) ? 16'h7FFF : 16'hFFFF;
  assign updatePixel = 1'b1;
  assign pong_cRGB2  = {1'b1, r2};

  always @(posedge clock) begin
    r1 <= 15'(y2 * H + x2);
    r2 <= r1;
  end

  pong_fb_writer #(.H_RES(H), .V_RES(V), .RENDER_LAT(0), .FIFO_DEPTH(4), .ADDR_W(AW)) u_dut (
    .clock(clock), .reset(reset), .frame_start(frame_start), .x(x), .y(y),
    .coord_valid(coord_valid), .pong_cRGB(pong_cRGB), .updatePixel(updatePixel),
    .wr_valid(wr_valid), .wr_ready(wr_ready), .wr_addr(wr_addr), .wr_data(wr_data),
    .busy(busy), .frame_done(frame_done), .frame_overrun(frame_overrun));

  pong_fb_writer #(.H_RES(H), .V_RES(V), .RENDER_LAT(2), .FIFO_DEPTH(4), .ADDR_W(AW)) u_dut_l2 (
    .clock(clock), .reset(reset), .frame_start(frame_start2), .x(x2), .y(y2),
    .coord_valid(coord_valid2), .pong_cRGB(pong_cRGB2), .updatePixel(1'b1),
    .wr_valid(wr_valid2), .wr_ready(wr_ready2), .wr_addr(wr_addr2), .wr_data(wr_data2),
    .busy(busy2), .frame_done(frame_done2), .frame_overrun(frame_overrun2));

  int errors = 0;
  int checks = 0;
  logic [AW+14:0] exp_q[$];
  logic [AW+14:0] exp2_q[$];
  int done_cnt = 0, ovr_cnt = 0, coord_cnt = 0, wr_cnt = 0;
  int done2_cnt = 0, ovr2_cnt = 0, coord2_cnt = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One clock: observe both write ports mid-cycle, then advance to just after the edge.
  task automatic step();
    logic [AW+14:0] e;
    @(negedge clock);
    if (wr_valid && wr_ready) begin
      wr_cnt++;
      if (exp_q.size() == 0) chk("unexpected_write", 32'({wr_addr, wr_data}), 32'hFFFF_FFFF);
      else begin
        e = exp_q.pop_front();
        chk("write", 32'({wr_addr, wr_data}), 32'(e));
      end
    end
    if (wr_valid2 && wr_ready2) begin
      if (exp2_q.size() == 0) chk("unexpected_write_l2", 32'({wr_addr2, wr_data2}), 32'hFFFF_FFFF);
      else begin
        e = exp2_q.pop_front();
        chk("write_l2", 32'({wr_addr2, wr_data2}), 32'(e));
      end
    end
    if (frame_done)     done_cnt++;
    if (frame_overrun)  ovr_cnt++;
    if (coord_valid)    coord_cnt++;
    if (frame_done2)    done2_cnt++;
    if (frame_overrun2) ovr2_cnt++;
    if (coord_valid2)   coord2_cnt++;
    @(posedge clock);
    #1;
  endtask

  task automatic push_frame(input bit even_only);
    for (int a = 0; a < H * V; a++)
      if (!even_only || (a % 2 == 0)) exp_q.push_back({AW'(a), 15'h7FFF});
  endtask

  task automatic start_frame();
    done_cnt = 0; ovr_cnt = 0; coord_cnt = 0; wr_cnt = 0;
    frame_start = 1'b1;
    step();
    frame_start = 1'b0;
  endtask

  task automatic run_to_done(input string tag);
    int n = 0;
    while (done_cnt == 0 && n < 400) begin step(); n++; end
    chk({tag, "_done"}, 32'(done_cnt), 32'd1);
    step(); step();
    chk({tag, "_done_once"}, 32'(done_cnt), 32'd1);
    chk({tag, "_queue_left"}, 32'(exp_q.size()), 32'd0);
    chk({tag, "_busy_after"}, 32'(busy), 32'd0);
  endtask

  initial begin
    int n;
    #12;
    chk("rst_xy", 32'({x, y}), 32'd0);
    chk("rst_wr", 32'({wr_valid, wr_addr, wr_data}), 32'd0);
    chk("rst_flags", 32'({coord_valid, busy, frame_done, frame_overrun}), 32'd0);
    @(posedge clock); #1;
    reset = 1'b0;
    step();

    // 1: full frame, always ready
    wr_ready = 1'b1; mode = 0;
    push_frame(0);
    start_frame();
    chk("t1_busy", 32'(busy), 32'd1);
    run_to_done("t1");

    // 2: back-pressure
    wr_ready = 1'b0;
    push_frame(0);
    start_frame();
    for (int i = 0; i < 20; i++) step();
    chk("t2_issued", 32'(coord_cnt), 32'd4);
    chk("t2_xy_hold", 32'({x, y}), 32'({11'd3, 11'd0}));
    chk("t2_head", 32'({wr_valid, wr_addr}), 32'({1'b1, AW'(0)}));
    for (int i = 0; i < 5; i++) step();
    chk("t2_head_stable", 32'({wr_valid, wr_addr, wr_data}), 32'({1'b1, AW'(0), 15'h7FFF}));
    chk("t2_still_stalled", 32'(coord_cnt), 32'd4);
    wr_ready = 1'b1;
    run_to_done("t2");

    // 3: odd columns not flagged for writing
    mode = 1;
    push_frame(1);
    start_frame();
    run_to_done("t3");
    chk("t3_writes", 32'(wr_cnt), 32'd16);
    mode = 0;

    // 4: frame_start while busy
    push_frame(0);
    start_frame();
    for (int i = 0; i < 10; i++) step();
    frame_start = 1'b1;
    step();
    frame_start = 1'b0;
    run_to_done("t4");
    chk("t4_overrun", 32'(ovr_cnt), 32'd1);

    // 5: reset mid-frame
    push_frame(0);
    start_frame();
    n = 0;
    while (wr_cnt < 10 && n < 100) begin step(); n++; end
    chk("t5_ten_writes", 32'(wr_cnt), 32'd10);
    reset = 1'b1;
    #1;
    chk("t5_rst_xy", 32'({x, y}), 32'd0);
    chk("t5_rst_wr", 32'({wr_valid, wr_addr, wr_data}), 32'd0);
    chk("t5_rst_flags", 32'({coord_valid, busy, frame_done, frame_overrun}), 32'd0);
    step(); step();
    reset = 1'b0;
    step(); step();
    chk("t5_no_done", 32'(done_cnt), 32'd0);
    exp_q.delete();
    push_frame(0);
    start_frame();
    run_to_done("t5_restart");

    // 6: two-stage renderer, random back-pressure
    for (int a = 0; a < H * V; a++) exp2_q.push_back({AW'(a), 15'(a)});
    done2_cnt = 0; ovr2_cnt = 0; coord2_cnt = 0;
    frame_start2 = 1'b1;
    step();
    frame_start2 = 1'b0;
    n = 0;
    while (done2_cnt == 0 && n < 600) begin
      wr_ready2 = 1'($urandom_range(0, 1));
      step();
      n++;
    end
    wr_ready2 = 1'b1;
    step();
    chk("t6_done", 32'(done2_cnt), 32'd1);
    chk("t6_queue_left", 32'(exp2_q.size()), 32'd0);
    chk("t6_coords", 32'(coord2_cnt), 32'(H * V));
    chk("t6_busy_overrun", 32'({busy2, 8'(ovr2_cnt)}), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
